// File: rtl/adder_tree_serial_reducer_if.sv
// Operand-in / sum-out bus of the serial group reducer.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid & ready are both 1.
// Valid is never withdrawn while waiting, and the payload stays stable until the beat transfers.
interface adder_tree_serial_reducer_if #(
    parameter int ADDER_WIDTH = 96,
    parameter int LOG2_GROUP  = 3
);
    logic                              in_valid;
    logic                              in_ready;
    logic [ADDER_WIDTH-1:0]            in_data;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [ADDER_WIDTH+LOG2_GROUP-1:0] out_sum;
    logic [LOG2_GROUP:0]               out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/adder_tree_serial_reducer.sv
// Serial group reducer: sums up to 2**LOG2_GROUP unsigned operands per group.
// A group ends early on in_last. Each group sum is offered with its operand count.
module adder_tree_serial_reducer #(
    parameter int ADDER_WIDTH = 96,
    parameter int LOG2_GROUP  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    adder_tree_serial_reducer_if.slave  bus_if,
    output logic                        dbg_state_o
);
    localparam int SW = ADDER_WIDTH + LOG2_GROUP;
    localparam int CW = LOG2_GROUP + 1;
    localparam logic [CW-1:0] GROUP_C = CW'(1 << LOG2_GROUP);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q;

    logic          accept;
    logic          closing;
    logic [CW-1:0] cnt_inc;
    logic [SW-1:0] operand;

    // armed_q holds in_ready low during reset and raises it on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    assign operand = {{LOG2_GROUP{1'b0}}, bus_if.in_data};
    assign cnt_inc = cnt_q + CW'(1);
    assign accept  = bus_if.in_valid && bus_if.in_ready;
    assign closing = (cnt_inc == GROUP_C) || bus_if.in_last;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = (cnt_q == '0) ? operand : acc_q + operand;
                    cnt_d = cnt_inc;
                    if (closing) state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus_if.out_ready) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign bus_if.in_ready  = armed_q && (state_q == ACC);
    assign bus_if.out_valid = (state_q == HOLD);
    assign bus_if.out_sum   = acc_q;
    assign bus_if.out_count = cnt_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_adder_tree_serial_reducer.sv
// Bench for adder_tree_serial_reducer: directed scenarios plus random groups,
// scored against a group-level model of accepted operands.
module tb_adder_tree_serial_reducer;
  localparam int W     = 96;
  localparam int L     = 3;
  localparam int GROUP = 1 << L;
  localparam int SW    = W + L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  adder_tree_serial_reducer_if #(.ADDER_WIDTH(W), .LOG2_GROUP(L)) bus ();

  adder_tree_serial_reducer #(.ADDER_WIDTH(W), .LOG2_GROUP(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_if      (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  grp[$];
  logic [SW-1:0] exp_q[$];
  logic [L:0]    exp_cnt_q[$];
  bit            m_hold  = 1'b0;
  bit            m_armed = 1'b0;

  always @(posedge rst) begin
    grp.delete();
    exp_q.delete();
    exp_cnt_q.delete();
    m_hold  = 1'b0;
    m_armed = 1'b0;
  end

  // Checks the present cycle, then predicts what the next rising edge does.
  always @(negedge clk) begin
    logic [SW-1:0] s;
    if (!rst) begin
      check("in_ready", bus.in_ready, m_armed && !m_hold);
      check("out_valid", bus.out_valid, m_hold);
      if (m_hold) begin
        check("out_sum", bus.out_sum, exp_q[0]);
        check("out_count", bus.out_count, exp_cnt_q[0]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_cnt_q.pop_front());
          m_hold = 1'b0;
        end
      end else if (m_armed && bus.in_valid) begin
        grp.push_back(bus.in_data);
        if (grp.size() == GROUP || bus.in_last) begin
          s = '0;
          foreach (grp[i]) s = s + SW'(grp[i]);
          exp_q.push_back(s);
          exp_cnt_q.push_back((L+1)'(grp.size()));
          grp.delete();
          m_hold = 1'b1;
        end
      end
      m_armed = 1'b1;
    end
  end

  // ---------------- drivers ----------------
  bit rand_ready = 1'b0;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int  n = 0;
    logic took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!took && n < 200) begin
      @(negedge clk);
      took = bus.in_ready;
      sync();
      n++;
    end
    if (!took) check("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = rand_word();
  endtask

  task automatic idle(input int n, input logic last);
    bus.in_valid = 1'b0;
    bus.in_last  = last;
    bus.in_data  = rand_word();
    repeat (n) sync();
    bus.in_last = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] max_sum;
    int            len;
    int            waited;
    max_sum = 99'h7_FFFF_FFFF_FFFF_FFFF_FFFF_FFF8;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sum", bus.out_sum, '0);
    check("rst_out_count", bus.out_count, '0);
    sync();
    rst = 1'b0;
    idle(2, 1'b0);

    // operands 1..8 back to back
    for (int i = 1; i <= GROUP; i++) send(W'(i), 1'b0);
    @(negedge clk);
    check("seq_valid", bus.out_valid, 1'b1);
    check("seq_sum", bus.out_sum, 36);
    check("seq_count", bus.out_count, 8);
    @(negedge clk);
    check("seq_ready_again", bus.in_ready, 1'b1);
    sync();

    // all-ones operands: no wrap
    for (int i = 0; i < GROUP; i++) send({W{1'b1}}, 1'b0);
    @(negedge clk);
    check("max_sum", bus.out_sum, max_sum);
    check("max_count", bus.out_count, 8);
    sync();

    // early close, then a single-operand group
    send(W'(5), 1'b0);
    send(W'(6), 1'b0);
    send(W'(7), 1'b1);
    @(negedge clk);
    check("early_sum", bus.out_sum, 18);
    check("early_count", bus.out_count, 3);
    sync();
    send(W'(9), 1'b1);
    @(negedge clk);
    check("single_sum", bus.out_sum, 9);
    check("single_count", bus.out_count, 1);
    sync();

    // downstream stall while upstream keeps offering
    bus.out_ready = 1'b0;
    for (int i = 0; i < GROUP; i++) send(rand_word(), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = rand_word();
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out_valid", bus.out_valid, 1'b1);
    end
    sync();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(2, 1'b0);

    // reset mid-group
    for (int i = 0; i < 4; i++) send(rand_word(), 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_sum", bus.out_sum, '0);
    check("midrst_out_count", bus.out_count, '0);
    #1 rst = 1'b0;
    for (int i = 0; i < GROUP; i++) send(W'(1), 1'b0);
    @(negedge clk);
    check("post_rst_sum", bus.out_sum, 8);
    check("post_rst_count", bus.out_count, 8);
    sync();

    // bubbles carrying an unqualified in_last
    for (int i = 1; i <= GROUP; i++) begin
      send(W'(i), 1'b0);
      if (i < GROUP) begin
        @(negedge clk);
        check("bubble_no_close", bus.out_valid, 1'b0);
        sync();
        idle(1, 1'b1);
      end
    end
    @(negedge clk);
    check("bubble_sum", bus.out_sum, 36);
    check("bubble_count", bus.out_count, 8);
    sync();

    // random groups, random bubbles, random backpressure
    rand_ready = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, GROUP);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        send(($urandom_range(0, 5) == 0) ? {W{1'b1}} : rand_word(),
             (i == len - 1) && (len < GROUP || $urandom_range(0, 1) == 1));
      end
    end
    rand_ready = 1'b0;
    sync();
    bus.out_ready = 1'b1;

    waited = 0;
    while ((exp_q.size() != 0 || m_hold) && waited < 100) begin
      sync();
      waited++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_partial", 32'(grp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/adder_tree_serial_reducer.md
ADDER_TREE_SERIAL_REDUCER -- requirements
Module: adder_tree_serial_reducer

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 96, operand width in bits.
REQ-002 SHALL have parameter LOG2_GROUP, default 3, log2 of operands per group (legal 1..4; GROUP = 2**LOG2_GROUP).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  operand can be accepted.
REQ-007 SHALL have port in_data  input  ADDER_WIDTH  unsigned operand.
REQ-008 SHALL have port in_last  input  1  operand closes current group early; qualified by in_valid.
REQ-009 SHALL have port out_valid  output  1  group sum present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts sum.
REQ-011 SHALL have port out_sum  output  ADDER_WIDTH+LOG2_GROUP  unsigned group sum.
REQ-012 SHALL have port out_count  output  LOG2_GROUP+1  number of operands in out_sum (1..GROUP).

Function
REQ-013 SHALL implement two states: ACC (accumulating) and HOLD (sum presented).
REQ-014 SHALL drive in_ready = 1 in ACC and 0 in HOLD; out_valid = 1 in HOLD and 0 in ACC.
REQ-015 SHALL accept an operand only on a cycle with in_valid & in_ready; cycles with in_valid = 0 have no effect on accumulator or count.
REQ-016 SHALL, on the first accept of a group, load the accumulator with in_data zero-extended; on later accepts, add in_data zero-extended to the accumulator.
REQ-017 SHALL increment the operand count by 1 per accept; the count resets to 0 on group start.
REQ-018 SHALL transition ACC -> HOLD on the accept that makes count equal GROUP, or on any accept with in_last = 1, whichever comes first.
REQ-019 SHALL present out_sum and out_count in the cycle after the closing accept (latency 1 cycle from the final operand handshake to out_valid).
REQ-020 SHALL hold out_sum and out_count stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL transition HOLD -> ACC on the cycle where out_valid & out_ready, with the count cleared; the next group's first accept occurs no earlier than the following cycle.
REQ-022 SHALL never overflow: the accumulator width ADDER_WIDTH+LOG2_GROUP holds GROUP*(2**ADDER_WIDTH-1).
REQ-023 SHALL treat in_last on a single operand as a group of 1 (out_count = 1, out_sum = operand).
REQ-024 SHALL ignore in_last when in_valid = 0, and ignore all inputs while in HOLD.
REQ-025 SHALL ignore out_ready while in ACC.
REQ-026 SHALL sustain one group per GROUP+1 cycles when in_valid and out_ready are held at 1.

Reset
REQ-027 SHALL, while rst = 1, force state ACC, count 0, accumulator 0, out_valid 0, out_sum 0, out_count 0, and in_ready 0.
REQ-028 SHALL assert in_ready on the first rising clk edge after rst deasserts.
REQ-029 SHALL discard a partial group or an unconsumed sum when rst asserts mid-operation; no sum from the interrupted group ever appears.

Verification
REQ-030 Scenario: GROUP=8, operands 1..8 back-to-back with out_ready = 1 -> out_valid one cycle after the 8th accept, out_sum = 36, out_count = 8, then in_ready high again.
REQ-031 Scenario: 8 operands each 2**96-1 -> out_sum = 8*(2**96-1) (99-bit value 0x7FF..FF8), no wrap.
REQ-032 Scenario: operands 5, 6, 7 with in_last on 7 -> out_sum = 18, out_count = 3; the next operand starts a fresh group.
REQ-033 Scenario: out_ready held 0 for 5 cycles in HOLD while in_valid = 1 -> out_sum/out_count stable, in_ready = 0, no operand consumed until out_ready = 1.
REQ-034 Scenario: rst pulsed after 4 accepts (async, mid-cycle) -> outputs reset immediately; the next 8 operands of value 1 yield out_sum = 8 exactly.
REQ-035 Scenario: in_valid toggling 1,0,1,0 with in_last = 1 on an in_valid = 0 cycle -> bubbles and the unqualified in_last have no effect; the group closes only at the 8th accept.
